// File: rtl/unified_mem_arbiter.sv
// Arbiter for the shared single-ported instruction/data memory. It grants IF or
// MEM for MEM_LAT cycles, pulses the matching done, and guards fetch against starvation.
module unified_mem_arbiter #(
  parameter int MEM_LAT    = 1,
  parameter int MAX_STREAK = 2,
  parameter int CNT_W      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       if_req,
  input  logic       mem_req,
  input  logic       mem_wr,
  output logic       addr_sel,
  output logic       mem_en,
  output logic       mem_we,
  output logic       if_done,
  output logic       mem_done,
  output logic       stall_if,
  output logic       stall_mem,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SERVE_IF  = 2'd1,
    SERVE_MEM = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAT_LAST   = CNT_W'(MEM_LAT - 1);
  localparam logic [CNT_W-1:0] STREAK_MAX = CNT_W'(MAX_STREAK);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] lat_q, lat_d;
  logic [CNT_W-1:0] streak_q, streak_d;
  logic             we_q, we_d;
  logic             addr_sel_q, mem_en_q, mem_we_q, if_done_q, mem_done_q;
  logic             addr_sel_d, mem_en_d, mem_we_d, if_done_d, mem_done_d;

  always_comb begin
    state_d  = state_q;
    lat_d    = lat_q;
    streak_d = streak_q;
    we_d     = we_q;
    case (state_q)
      IDLE: begin
        if (!if_req) streak_d = '0;
        // MEM is the older instruction and wins unless fetch has waited MAX_STREAK grants.
        if (mem_req && !(if_req && streak_q == STREAK_MAX)) begin
          state_d = SERVE_MEM;
          lat_d   = '0;
          we_d    = mem_wr;
          if (if_req && streak_q < STREAK_MAX) streak_d = streak_q + CNT_W'(1);
        end else if (if_req) begin
          state_d  = SERVE_IF;
          lat_d    = '0;
          streak_d = '0;
        end
      end
      SERVE_IF, SERVE_MEM: begin
        if (lat_q == LAT_LAST) state_d = IDLE;
        else                   lat_d   = lat_q + CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from next-state so they line up with the grant cycle.
    addr_sel_d = (state_d == SERVE_MEM);
    mem_en_d   = (state_d != IDLE);
    mem_we_d   = (state_d == SERVE_MEM) && we_d;
    if_done_d  = (state_d == SERVE_IF)  && (lat_d == LAT_LAST);
    mem_done_d = (state_d == SERVE_MEM) && (lat_d == LAT_LAST);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      lat_q      <= '0;
      streak_q   <= '0;
      we_q       <= 1'b0;
      addr_sel_q <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      if_done_q  <= 1'b0;
      mem_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lat_q      <= lat_d;
      streak_q   <= streak_d;
      we_q       <= we_d;
      addr_sel_q <= addr_sel_d;
      mem_en_q   <= mem_en_d;
      mem_we_q   <= mem_we_d;
      if_done_q  <= if_done_d;
      mem_done_q <= mem_done_d;
    end
  end

  assign addr_sel  = addr_sel_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign if_done   = if_done_q;
  assign mem_done  = mem_done_q;
  assign stall_if  = if_req  & ~if_done_q;
  assign stall_mem = mem_req & ~mem_done_q;
  assign dbg_state = state_q;

endmodule
